io_gpio_in: RTL and testbench

//  Debounced general-purpose input port on the dma_io peripheral bus. Synchronises and debounces

---
 rtl/io_gpio_in_pkg.sv | 28 ++
 rtl/io_gpio_deb.sv | 126 ++++++++++++
 rtl/io_gpio_in.sv | 175 +++++++++++++++++
 tb/tb_io_gpio_in.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_gpio_in_pkg.sv
// io_gpio_in_pkg
//   Shared constants for the dma_io peripheral bus: register word offsets of
//   the GPIO input block, the bit position of the fall-status field, the
//   debouncer state encoding and the dma_io base word addresses of the
//   peripherals on the bus.
package io_gpio_in_pkg;

  // Word offsets from a peripheral's base address (address bits [1:0]).
  localparam logic [1:0] OFS_DATA = 2'd0;
  localparam logic [1:0] OFS_STAT = 2'd1;
  localparam logic [1:0] OFS_EN   = 2'd2;
  localparam logic [1:0] OFS_DEB  = 2'd3;

  // STAT/EN layout: rise bits at [GPIO_W-1:0], fall bits from this position up.
  localparam int STAT_FALL_BASE = 16;

  // dma_io base word addresses ([15:2]) of the bus peripherals.
  localparam logic [13:0] BASE_ADR_IO_FRC     = 14'h3F30;
  localparam logic [13:0] BASE_ADR_IO_GPIO_IN = 14'h3F40;
  localparam logic [13:0] BASE_ADR_IO_GPIO_OUT = 14'h3F44;

  // Per-pin debouncer state.
  typedef enum logic [0:0] {
    DEB_STABLE  = 1'b0,
    DEB_PENDING = 1'b1
  } deb_state_e;

endpackage

// File: rtl/io_gpio_deb.sv
// io_gpio_deb
//   One pin of the GPIO input port: 2-flop synchroniser followed by a
//   STABLE/PENDING debounce FSM. A new level is accepted once the synchronised
//   pin has differed from the current level for deb+1 prescaler ticks; the
//   accepted transition is reported as a 1-clk rise or fall pulse that is
//   registered together with the new level.
// Ports
//   clk     in  system clock
//   rst_n   in  synchronous reset, active-high
//   tick    in  1-clk debounce tick from the shared prescaler
//   deb     in  [DEB_W-1:0] stable-tick threshold (0 = one tick)
//   restart in  abandon any pending attempt (threshold was rewritten)
//   pin     in  asynchronous external pin
//   level   out debounced level
//   rise    out 1-clk pulse on an accepted 0->1 transition
//   fall    out 1-clk pulse on an accepted 1->0 transition
module io_gpio_deb
  import io_gpio_in_pkg::*;
#(
  parameter int DEB_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [DEB_W-1:0] deb,
  input  logic             restart,
  input  logic             pin,
  output logic             level,
  output logic             rise,
  output logic             fall
);

  logic [1:0]       r_sync;
  deb_state_e       r_state;
  logic [DEB_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;

  logic             w_sync;
  deb_state_e       w_state_nxt;
  logic [DEB_W-1:0] w_cnt_nxt;
  logic             w_level_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  assign w_sync = r_sync[1];

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], pin};
    end
  end

  // Debounce FSM state, counter, level and edge-pulse registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= DEB_STABLE;
      r_cnt   <= {DEB_W{1'b0}};
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Next-state logic. The counter stops at the compare value, so it never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    if (restart) begin
      // New threshold: drop any attempt in progress, keep the level.
      w_state_nxt = DEB_STABLE;
      w_cnt_nxt   = {DEB_W{1'b0}};
    end else begin
      case (r_state)
        DEB_STABLE: begin
          if (w_sync != r_level) begin
            w_state_nxt = DEB_PENDING;
            w_cnt_nxt   = {DEB_W{1'b0}};
          end else begin
            w_state_nxt = DEB_STABLE;
          end
        end
        DEB_PENDING: begin
          if (w_sync == r_level) begin
            // Pin went back before the threshold: glitch, no edge.
            w_state_nxt = DEB_STABLE;
          end else if (tick) begin
            if (r_cnt == deb) begin
              w_level_nxt = w_sync;
              w_rise_nxt  = w_sync;
              w_fall_nxt  = ~w_sync;
              w_state_nxt = DEB_STABLE;
              w_cnt_nxt   = {DEB_W{1'b0}};
            end else begin
              w_cnt_nxt = r_cnt + DEB_W'(1'b1);
            end
          end else begin
            w_state_nxt = DEB_PENDING;
          end
        end
        default: begin
          w_state_nxt = DEB_STABLE;
          w_cnt_nxt   = {DEB_W{1'b0}};
        end
      endcase
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

// File: rtl/io_gpio_in.sv
// io_gpio_in
//   Debounced GPIO input port on the dma_io bus. Each pin is synchronised and
//   debounced; accepted edges set sticky W1C status bits (when enabled) and
//   gpio_irq is the OR of all status bits. Read data joins the dma_io read
//   daisy chain: a hit is answered one clock later, otherwise the upstream
//   data passes through.
//   Registers (word offset from BASE_ADR):
//     +0 DATA RO  [GPIO_W-1:0] debounced levels
//     +1 STAT W1C [GPIO_W-1:0] rise seen, [GPIO_W+15:16] fall seen
//     +2 EN   RW  edge-capture enables, STAT layout
//     +3 DEB  RW  [DEB_W-1:0] stable-tick threshold
// Ports
//   clk, rst_n            clock, synchronous active-high reset
//   dma_io_we/wadr/wdata  bus write
//   dma_io_radr/radr_en   bus read request
//   dma_io_rdata_in       read data from the upstream chain element
//   dma_io_rdata          read data to the downstream element / CPU
//   gpio_in               asynchronous pins
//   gpio_irq              level interrupt, OR of STAT
module io_gpio_in
  import io_gpio_in_pkg::*;
#(
  parameter int          GPIO_W   = 8,
  parameter logic [13:0] BASE_ADR = BASE_ADR_IO_GPIO_IN,
  parameter int          PRESC_W  = 10,
  parameter int          DEB_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dma_io_we,
  input  logic [13:0]       dma_io_wadr,
  input  logic [31:0]       dma_io_wdata,
  input  logic [13:0]       dma_io_radr,
  input  logic              dma_io_radr_en,
  input  logic [31:0]       dma_io_rdata_in,
  output logic [31:0]       dma_io_rdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              gpio_irq
);

  logic [PRESC_W-1:0] r_presc;
  logic [GPIO_W-1:0]  r_stat_rise;
  logic [GPIO_W-1:0]  r_stat_fall;
  logic [GPIO_W-1:0]  r_en_rise;
  logic [GPIO_W-1:0]  r_en_fall;
  logic [DEB_W-1:0]   r_deb;
  logic               r_rd_hit;
  logic [31:0]        r_rd_data;

  logic               w_tick;
  logic [GPIO_W-1:0]  w_level;
  logic [GPIO_W-1:0]  w_rise;
  logic [GPIO_W-1:0]  w_fall;
  logic               w_wr_stat;
  logic               w_wr_en;
  logic               w_wr_deb;
  logic               w_rd_hit;
  logic [31:0]        w_rd_mux;

  // Place a rise/fall pair into the 32-bit STAT/EN layout; other bits read 0.
  function automatic logic [31:0] pack_pair(input logic [GPIO_W-1:0] lo,
                                            input logic [GPIO_W-1:0] hi);
    logic [31:0] v;
    v = 32'd0;
    v[GPIO_W-1:0] = lo;
    v[STAT_FALL_BASE +: GPIO_W] = hi;
    return v;
  endfunction

  assign w_tick = (r_presc == {PRESC_W{1'b0}});

  // Free-running debounce prescaler; tick while it sits at 0.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_presc <= {PRESC_W{1'b0}};
    end else begin
      r_presc <= r_presc + PRESC_W'(1'b1);
    end
  end

  for (genvar g = 0; g < GPIO_W; g++) begin : g_pin
    io_gpio_deb #(
      .DEB_W(DEB_W)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (w_tick),
      .deb    (r_deb),
      .restart(w_wr_deb),
      .pin    (gpio_in[g]),
      .level  (w_level[g]),
      .rise   (w_rise[g]),
      .fall   (w_fall[g])
    );
  end

  // Write address decode; DATA and foreign addresses produce no strobe.
  always_comb begin
    w_wr_stat = 1'b0;
    w_wr_en   = 1'b0;
    w_wr_deb  = 1'b0;
    if (dma_io_we && (dma_io_wadr[13:2] == BASE_ADR[13:2])) begin
      case (dma_io_wadr[1:0])
        OFS_STAT: w_wr_stat = 1'b1;
        OFS_EN:   w_wr_en   = 1'b1;
        OFS_DEB:  w_wr_deb  = 1'b1;
        default:  w_wr_stat = 1'b0;
      endcase
    end else begin
      w_wr_stat = 1'b0;
    end
  end

  // Sticky edge status: a new edge overrides a simultaneous W1C of the same bit.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_stat_rise <= {GPIO_W{1'b0}};
      r_stat_fall <= {GPIO_W{1'b0}};
    end else if (w_wr_stat) begin
      r_stat_rise <= (r_stat_rise & ~dma_io_wdata[GPIO_W-1:0]) | (w_rise & r_en_rise);
      r_stat_fall <= (r_stat_fall & ~dma_io_wdata[STAT_FALL_BASE +: GPIO_W]) |
                     (w_fall & r_en_fall);
    end else begin
      r_stat_rise <= r_stat_rise | (w_rise & r_en_rise);
      r_stat_fall <= r_stat_fall | (w_fall & r_en_fall);
    end
  end

  // Edge-capture enables and debounce threshold.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_en_rise <= {GPIO_W{1'b0}};
      r_en_fall <= {GPIO_W{1'b0}};
      r_deb     <= {DEB_W{1'b1}};
    end else begin
      if (w_wr_en) begin
        r_en_rise <= dma_io_wdata[GPIO_W-1:0];
        r_en_fall <= dma_io_wdata[STAT_FALL_BASE +: GPIO_W];
      end
      if (w_wr_deb) begin
        r_deb <= dma_io_wdata[DEB_W-1:0];
      end
    end
  end

  // Read mux on current register contents (a same-cycle write is not visible).
  always_comb begin
    w_rd_hit = dma_io_radr_en && (dma_io_radr[13:2] == BASE_ADR[13:2]);
    w_rd_mux = 32'd0;
    case (dma_io_radr[1:0])
      OFS_DATA: w_rd_mux = pack_pair(w_level, {GPIO_W{1'b0}});
      OFS_STAT: w_rd_mux = pack_pair(r_stat_rise, r_stat_fall);
      OFS_EN:   w_rd_mux = pack_pair(r_en_rise, r_en_fall);
      OFS_DEB:  w_rd_mux[DEB_W-1:0] = r_deb;
      default:  w_rd_mux = 32'd0;
    endcase
  end

  // Read response register: one cycle of latency on an address hit.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_rd_hit  <= 1'b0;
      r_rd_data <= 32'd0;
    end else begin
      r_rd_hit <= w_rd_hit;
      if (w_rd_hit) begin
        r_rd_data <= w_rd_mux;
      end
    end
  end

  assign dma_io_rdata = r_rd_hit ? r_rd_data : dma_io_rdata_in;
  assign gpio_irq     = |{r_stat_rise, r_stat_fall};

endmodule

// File: tb/tb_io_gpio_in.sv
module tb_io_gpio_in;
  import io_gpio_in_pkg::*;

  localparam int          GPIO_W  = 8;
  localparam int          PRESC_W = 2;
  localparam int          DEB_W   = 4;
  localparam logic [13:0] BASE    = 14'h3F40;

  logic              clk;
  logic              rst_n;
  logic              we;
  logic [13:0]       wadr;
  logic [31:0]       wdata;
  logic [13:0]       radr;
  logic              radr_en;
  logic [31:0]       rdata_in;
  logic [31:0]       rdata;
  logic [GPIO_W-1:0] gpio;
  logic              irq;

  int n_checks = 0;
  int n_pass   = 0;

  io_gpio_in #(
    .GPIO_W  (GPIO_W),
    .BASE_ADR(BASE),
    .PRESC_W (PRESC_W),
    .DEB_W   (DEB_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dma_io_we      (we),
    .dma_io_wadr    (wadr),
    .dma_io_wdata   (wdata),
    .dma_io_radr    (radr),
    .dma_io_radr_en (radr_en),
    .dma_io_rdata_in(rdata_in),
    .dma_io_rdata   (rdata),
    .gpio_in        (gpio),
    .gpio_irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected prescaler phase: value of the tick counter during the current cycle.
  logic [1:0] m_presc;
  always @(posedge clk) begin
    if (rst_n) m_presc <= 2'd0;
    else       m_presc <= m_presc + 2'd1;
  end

  typedef struct {
    bit          wr;
    logic [2:0]  off;
    logic [31:0] data;
    logic [31:0] rin;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic bus_write(input logic [13:0] adr, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; wadr = adr; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Read: data expected in cycle N+1, upstream passthrough in cycle N+2.
  task automatic bus_read(input string name, input logic [13:0] adr,
                          input logic [31:0] exp, input logic [31:0] rin);
    @(negedge clk);
    rdata_in = rin; radr = adr; radr_en = 1'b1;
    @(negedge clk);
    radr_en = 1'b0;
    check(name, rdata, exp);
    @(negedge clk);
    check({name, "_pass"}, rdata, rin);
  endtask

  task automatic wait_irq(input int limit, output int cyc);
    cyc = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (irq) begin
        cyc = k;
        break;
      end
    end
  endtask

  // Stop on a negedge whose cycle has the given prescaler value.
  task automatic align(input logic [1:0] ph);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (m_presc == ph) break;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b1; we = 1'b0; wadr = 14'd0; wdata = 32'd0;
    radr = 14'd0; radr_en = 1'b0; rdata_in = 32'hDEADBEEF; gpio = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_passthru", rdata, 32'hDEADBEEF);

    // Register map, reset values, read masks and ignored writes.
    vt[0]  = '{1'b0, 3'd0, 32'd0,          32'hDEADBEEF, 32'h0000_0000};
    vt[1]  = '{1'b0, 3'd1, 32'd0,          32'hDEADBEEF, 32'h0000_0000};
    vt[2]  = '{1'b0, 3'd2, 32'd0,          32'hDEADBEEF, 32'h0000_0000};
    vt[3]  = '{1'b0, 3'd3, 32'd0,          32'hDEADBEEF, 32'h0000_000F};
    vt[4]  = '{1'b0, 3'd4, 32'd0,          32'hDEADBEEF, 32'hDEADBEEF};
    vt[5]  = '{1'b1, 3'd2, 32'hFFFF_FFFF,  32'd0,        32'd0};
    vt[6]  = '{1'b0, 3'd2, 32'd0,          32'h1111_1111, 32'h00FF_00FF};
    vt[7]  = '{1'b1, 3'd3, 32'hFFFF_FFF2,  32'd0,        32'd0};
    vt[8]  = '{1'b0, 3'd3, 32'd0,          32'h2222_2222, 32'h0000_0002};
    vt[9]  = '{1'b1, 3'd0, 32'h0000_0055,  32'd0,        32'd0};
    vt[10] = '{1'b0, 3'd0, 32'd0,          32'h3333_3333, 32'h0000_0000};
    vt[11] = '{1'b1, 3'd5, 32'h0000_0000,  32'd0,        32'd0};
    vt[12] = '{1'b0, 3'd2, 32'd0,          32'h4444_4444, 32'h00FF_00FF};
    vt[13] = '{1'b1, 3'd2, 32'h0000_0000,  32'd0,        32'd0};
    vt[14] = '{1'b0, 3'd2, 32'd0,          32'h5555_5555, 32'h0000_0000};
    vt[15] = '{1'b0, 3'd7, 32'd0,          32'h1234_5678, 32'h1234_5678};
    for (int i = 0; i < 16; i++) begin
      if (vt[i].wr) bus_write(BASE + {11'd0, vt[i].off}, vt[i].data);
      else bus_read($sformatf("vec%0d", i), BASE + {11'd0, vt[i].off}, vt[i].exp, vt[i].rin);
    end

    // Rise on pin0 with DEB=2: three ticks after the synchroniser.
    bus_write(BASE + 14'd2, 32'h0000_0001);
    bus_write(BASE + 14'd3, 32'h0000_0002);
    gpio[0] = 1'b1;
    wait_irq(40, cyc);
    check("rise_latency", {31'd0, (cyc >= 13 && cyc <= 16)}, 32'd1);
    bus_read("rise_data", BASE, 32'h0000_0001, 32'hA0A0_A0A0);
    bus_read("rise_stat", BASE + 14'd1, 32'h0000_0001, 32'hA0A0_A0A0);
    check("rise_irq", {31'd0, irq}, 32'd1);
    bus_write(BASE + 14'd1, 32'h0000_0001);
    check("w1c_irq", {31'd0, irq}, 32'd0);
    bus_read("w1c_stat", BASE + 14'd1, 32'h0000_0000, 32'hA0A0_A0A0);

    // Glitch on pin3 with DEB=0, placed between ticks.
    bus_write(BASE + 14'd3, 32'h0000_0000);
    bus_write(BASE + 14'd2, 32'h0008_0008);
    align(2'd2);
    gpio[3] = 1'b1;
    repeat (3) @(negedge clk);
    gpio[3] = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_irq", {31'd0, irq}, 32'd0);
    bus_read("glitch_data", BASE, 32'h0000_0001, 32'hB0B0_B0B0);
    bus_read("glitch_stat", BASE + 14'd1, 32'h0000_0000, 32'hB0B0_B0B0);

    // Fall on pin0.
    bus_write(BASE + 14'd2, 32'h0001_0000);
    gpio[0] = 1'b0;
    wait_irq(40, cyc);
    check("fall_seen", {31'd0, (cyc > 0)}, 32'd1);
    bus_read("fall_stat", BASE + 14'd1, 32'h0001_0000, 32'hC0C0_C0C0);
    bus_write(BASE + 14'd1, 32'h0001_0000);
    gpio[0] = 1'b1;
    repeat (20) @(negedge clk);
    bus_read("refill_data", BASE, 32'h0000_0001, 32'hC0C0_C0C0);
    check("refill_irq", {31'd0, irq}, 32'd0);
    // Second fall with a W1C of bit 16 in the fall-pulse cycle: set wins.
    align(2'd1);
    gpio[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_edge_irq", {31'd0, irq}, 32'd0);
    we = 1'b1; wadr = BASE + 14'd1; wdata = 32'h0001_0000;
    @(negedge clk);
    we = 1'b0;
    check("setwins_irq", {31'd0, irq}, 32'd1);
    bus_read("setwins_stat", BASE + 14'd1, 32'h0001_0000, 32'hC0C0_C0C0);

    // Pin5 rise interrupted by a DEB write.
    bus_write(BASE + 14'd2, 32'h0020_0020);
    bus_write(BASE + 14'd1, 32'hFFFF_FFFF);
    bus_write(BASE + 14'd3, 32'h0000_000F);
    gpio[5] = 1'b1;
    repeat (10) @(negedge clk);
    bus_write(BASE + 14'd3, 32'h0000_000F);
    repeat (57) @(negedge clk);
    check("restart_irq", {31'd0, irq}, 32'd0);
    bus_read("restart_data", BASE, 32'h0000_0000, 32'hD0D0_D0D0);
    wait_irq(100, cyc);
    check("retry_seen", {31'd0, (cyc > 0)}, 32'd1);
    bus_read("retry_data", BASE, 32'h0000_0020, 32'hD0D0_D0D0);
    bus_read("retry_stat", BASE + 14'd1, 32'h0000_0020, 32'hD0D0_D0D0);

    // Pin5 fall interrupted by reset.
    bus_write(BASE + 14'd1, 32'hFFFF_FFFF);
    gpio[5] = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    check("rst2_irq", {31'd0, irq}, 32'd0);
    bus_read("rst2_data", BASE, 32'h0000_0000, 32'hE0E0_E0E0);
    bus_read("rst2_stat", BASE + 14'd1, 32'h0000_0000, 32'hE0E0_E0E0);
    bus_read("rst2_en", BASE + 14'd2, 32'h0000_0000, 32'hE0E0_E0E0);
    bus_read("rst2_deb", BASE + 14'd3, 32'h0000_000F, 32'hE0E0_E0E0);

    // Multi-pin pattern, back-to-back reads, read during write.
    bus_write(BASE + 14'd2, 32'h0000_000F);
    gpio = 8'hA5;
    wait_irq(120, cyc);
    check("multi_seen", {31'd0, (cyc > 0)}, 32'd1);
    repeat (70) @(negedge clk);
    bus_read("multi_data", BASE, 32'h0000_00A5, 32'hF0F0_F0F0);
    @(negedge clk);
    rdata_in = 32'hCAFE_F00D; radr = BASE; radr_en = 1'b1;
    @(negedge clk);
    check("b2b_data", rdata, 32'h0000_00A5);
    radr = BASE + 14'd1;
    @(negedge clk);
    check("b2b_stat", rdata, 32'h0000_0005);
    radr_en = 1'b0;
    @(negedge clk);
    check("b2b_pass", rdata, 32'hCAFE_F00D);
    we = 1'b1; wadr = BASE + 14'd2; wdata = 32'h0000_00FF;
    radr = BASE + 14'd2; radr_en = 1'b1;
    @(negedge clk);
    we = 1'b0; radr_en = 1'b0;
    check("rdw_old", rdata, 32'h0000_000F);
    bus_read("rdw_new", BASE + 14'd2, 32'h0000_00FF, 32'hF0F0_F0F0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
